// File: rtl/sccb_reg_sequencer_if.sv
// ----------------------------------------------------------------------------
// sccb_reg_sequencer_if
// Write-command handshake between the register sequencer and the SCCB write
// engine. The sequencer drives a command and holds it stable until the engine
// accepts it with cmd_ready.
//
// Signals:
//   cmd_valid  write command pending (sequencer -> engine)
//   cmd_ready  engine accepts the pending command (engine -> sequencer)
//   cmd_id     SCCB device write ID
//   cmd_addr   register address
//   cmd_data   register data
// Modports: master = sequencer side, slave = SCCB engine side.
// ----------------------------------------------------------------------------
interface sccb_reg_sequencer_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [7:0] cmd_id;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;

    modport master (
        output cmd_valid,
        output cmd_id,
        output cmd_addr,
        output cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_id,
        input  cmd_addr,
        input  cmd_data,
        output cmd_ready
    );
endinterface

// File: rtl/sccb_reg_sequencer.sv
// ----------------------------------------------------------------------------
// sccb_reg_sequencer
// Walks a register-table ROM of {reg_addr, reg_data} pairs and issues one SCCB
// write command at a time over a valid/ready handshake. Entries with
// reg_addr 8'hFE are millisecond delays, 16'hFFFF ends the table, and the
// last ROM location ends the table implicitly (no wrap). A power-up wait of
// STARTUP_MS ms precedes the first fetch.
//
// Ports:
//   PCLK      system clock
//   PRESETN   asynchronous active-low reset
//   start     one-cycle pulse, accepted only in IDLE or DONE
//   rom_addr  table address; rom_data is expected one cycle later
//   rom_data  table word, [15:8] = reg_addr, [7:0] = reg_data
//   cmd       write-command handshake (master side)
//   busy      sequence in progress
//   done      sequence completed, sticky until next start or reset
//   wr_count  writes accepted in the current sequence
// ----------------------------------------------------------------------------
module sccb_reg_sequencer #(
    parameter logic [7:0]  DEV_ID     = 8'h42,
    parameter int unsigned ROM_AW     = 8,
    parameter int unsigned MS_CYCLES  = 25000,
    parameter int unsigned STARTUP_MS = 20
) (
    input  logic                  PCLK,
    input  logic                  PRESETN,
    input  logic                  start,
    output logic [ROM_AW-1:0]     rom_addr,
    input  logic [15:0]           rom_data,
    sccb_reg_sequencer_if.master  cmd,
    output logic                  busy,
    output logic                  done,
    output logic [ROM_AW:0]       wr_count
);

    // Tick counter runs 0..MS_CYCLES-1, so it never needs to hold MS_CYCLES.
    localparam int unsigned       TW          = (MS_CYCLES > 1) ? $clog2(MS_CYCLES) : 1;
    localparam logic [TW-1:0]     TICK_LAST   = TW'(MS_CYCLES - 1);
    localparam logic [ROM_AW-1:0] ADDR_LAST   = '1;
    localparam logic [7:0]        STARTUP_CNT = 8'(STARTUP_MS);

    typedef enum logic [2:0] {
        StIdle,
        StPwrup,
        StFetch,
        StDecode,
        StIssue,
        StDelay,
        StDone
    } state_e;

    state_e              state_q;
    logic [ROM_AW-1:0]   rom_addr_q;
    logic [ROM_AW:0]     wr_count_q;
    logic [TW-1:0]       tick_q;
    logic [7:0]          ms_q;
    logic                cmd_valid_q;
    logic [7:0]          cmd_addr_q;
    logic [7:0]          cmd_data_q;
    logic                busy_q;
    logic                done_q;

    assign rom_addr      = rom_addr_q;
    assign wr_count      = wr_count_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign cmd.cmd_valid = cmd_valid_q;
    assign cmd.cmd_addr  = cmd_addr_q;
    assign cmd.cmd_data  = cmd_data_q;
    assign cmd.cmd_id    = DEV_ID;

    always_ff @(posedge PCLK or negedge PRESETN) begin
        if (!PRESETN) begin
            state_q     <= StIdle;
            rom_addr_q  <= '0;
            wr_count_q  <= '0;
            tick_q      <= '0;
            ms_q        <= '0;
            cmd_valid_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_data_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        state_q    <= StPwrup;
                        busy_q     <= 1'b1;
                        done_q     <= 1'b0;
                        rom_addr_q <= '0;
                        wr_count_q <= '0;
                        ms_q       <= STARTUP_CNT;
                        tick_q     <= '0;
                    end
                end

                // With ms_q already zero this state lasts exactly one cycle.
                StPwrup: begin
                    if (ms_q == 8'd0) begin
                        state_q <= StFetch;
                    end else if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        ms_q   <= ms_q - 8'(1);
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end

                // rom_addr has been stable since entry; data is valid next cycle.
                StFetch: begin
                    state_q <= StDecode;
                end

                StDecode: begin
                    if (rom_data == 16'hFFFF) begin
                        state_q     <= StDone;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cmd_valid_q <= 1'b0;
                    end else if (rom_data[15:8] == 8'hFE) begin
                        ms_q    <= rom_data[7:0];
                        tick_q  <= '0;
                        state_q <= StDelay;
                    end else begin
                        cmd_addr_q  <= rom_data[15:8];
                        cmd_data_q  <= rom_data[7:0];
                        cmd_valid_q <= 1'b1;
                        state_q     <= StIssue;
                    end
                end

                StIssue: begin
                    if (cmd.cmd_ready) begin
                        cmd_valid_q <= 1'b0;
                        wr_count_q  <= wr_count_q + (ROM_AW + 1)'(1);
                        // The last ROM slot terminates the table instead of wrapping.
                        if (rom_addr_q == ADDR_LAST) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rom_addr_q <= rom_addr_q + ROM_AW'(1);
                            state_q    <= StFetch;
                        end
                    end
                end

                StDelay: begin
                    if (ms_q == 8'd0) begin
                        if (rom_addr_q == ADDR_LAST) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            rom_addr_q <= rom_addr_q + ROM_AW'(1);
                            state_q    <= StFetch;
                        end
                    end else if (tick_q == TICK_LAST) begin
                        tick_q <= '0;
                        ms_q   <= ms_q - 8'(1);
                    end else begin
                        tick_q <= tick_q + TW'(1);
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
